// File: rtl/uart_pkg.sv
// uart_pkg: state encodings and default payload width shared by the UART TX and RX blocks.
package uart_pkg;
    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
endpackage

// File: rtl/uart_tx_parity_calc.sv
// uart_tx_parity_calc: registered parity of the payload, captured when a frame is accepted.
module uart_tx_parity_calc
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  CLK_UART_TX,
    input  logic                  RST_UART_TX,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  par_bit
);
    always_ff @(posedge CLK_UART_TX or posedge RST_UART_TX)
        if (RST_UART_TX)
            par_bit <= 1'b0;
        else if (load)
            par_bit <= ^data ^ par_typ;
endmodule

// File: rtl/uart_tx_core.sv
// uart_tx_core: UART serializer; the state register always names the bit currently on the line.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  CLK_UART_TX,
    input  logic                  RST_UART_TX,
    input  logic [DATA_WIDTH-1:0] P_DATA_UART_TX,
    input  logic                  Data_Valid_UART_TX,
    input  logic                  PAR_EN_UART_TX,
    input  logic                  PAR_TYP_UART_TX,
    output logic                  TX_OUT_UART_TX,
    output logic                  Busy_UART_TX
);
    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
    logic [2:0]            state;
    logic [DATA_WIDTH-1:0] data_q;
    logic [CW-1:0]         bit_cnt;
    logic                  par_en_q;
    logic                  par_bit;
    logic                  accept;
    assign accept = (state == S_IDLE) && Data_Valid_UART_TX;
    uart_tx_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
        .CLK_UART_TX(CLK_UART_TX),
        .RST_UART_TX(RST_UART_TX),
        .load(accept),
        .data(P_DATA_UART_TX),
        .par_typ(PAR_TYP_UART_TX),
        .par_bit(par_bit)
    );
    always_ff @(posedge CLK_UART_TX or posedge RST_UART_TX)
        if (RST_UART_TX) begin
            state          <= S_IDLE;
            TX_OUT_UART_TX <= 1'b1;
            Busy_UART_TX   <= 1'b0;
            bit_cnt        <= '0;
            data_q         <= '0;
            par_en_q       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (Data_Valid_UART_TX) begin
                    state          <= S_START;
                    TX_OUT_UART_TX <= 1'b0;
                    Busy_UART_TX   <= 1'b1;
                    data_q         <= P_DATA_UART_TX;
                    par_en_q       <= PAR_EN_UART_TX;
                    bit_cnt        <= '0;
                end
                S_START: begin
                    state          <= S_DATA;
                    TX_OUT_UART_TX <= data_q[0];
                    data_q         <= data_q >> 1;
                    bit_cnt        <= '0;
                end
                // bit_cnt indexes the data bit currently on the line
                S_DATA: if (bit_cnt == LAST) begin
                    state          <= par_en_q ? S_PARITY : S_STOP;
                    TX_OUT_UART_TX <= par_en_q ? par_bit : 1'b1;
                end else begin
                    TX_OUT_UART_TX <= data_q[0];
                    data_q         <= data_q >> 1;
                    bit_cnt        <= bit_cnt + 1'b1;
                end
                S_PARITY: begin
                    state          <= S_STOP;
                    TX_OUT_UART_TX <= 1'b1;
                end
                S_STOP: begin
                    state          <= S_IDLE;
                    TX_OUT_UART_TX <= 1'b1;
                    Busy_UART_TX   <= 1'b0;
                end
                default: begin
                    state          <= S_IDLE;
                    TX_OUT_UART_TX <= 1'b1;
                    Busy_UART_TX   <= 1'b0;
                end
            endcase
        end
endmodule
